fetch_buf: RTL and testbench
============================

# fetch_buf

Parametrised instruction-fetch unit that replaces the single-register PC stage of the five-stage core. It owns the PC, issues pipelined requests to instruction ROM through a request/grant handshake, and tolerates variable in-order response latency. Fetched {pc, inst} pairs are buffered in a DEPTH-entry queue and presented to the IF/ID register through a valid/ready handshake. A branch redirect flushes the queue and discards in-flight responses.

## Interface
- ADDR_W, 32, PC / ROM address width
- DATA_W, 32, instruction width
- DEPTH, 4, queue slots; power of two, ≥2
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, increment per sequential fetch
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset; rst=0 resets all state
- rom_req_o  out  1  fetch request; also serves as ROM chip enable
- rom_addr_o  out  ADDR_W  fetch address; equals current PC
- rom_gnt_i  in  1  ROM accepts the request this cycle when rom_req_o & rom_gnt_i
- rom_rvalid_i  in  1  one response, in request order
- rom_data_i  in  DATA_W  instruction paired with rom_rvalid_i
- branch_flag_i  in  1  redirect pulse
- branch_target_i  in  ADDR_W  new PC when branch_flag_i=1
- id_valid_o  out  1  head entry available
- id_pc_o  out  ADDR_W  PC of the head entry
- id_inst_o  out  DATA_W  instruction of the head entry
- id_ready_i  in  1  consumer takes the head when id_valid_o & id_ready_i

## Operation
- Slots are allocated at issue: on request accept (req&gnt), pc is written into slot[alloc_ptr], alloc_ptr++, and pc += PC_STEP (wraps modulo 2^ADDR_W).
- Response fill: when rom_rvalid_i=1 and discard_cnt=0, rom_data_i is written into slot[fill_ptr] and fill_ptr++.
- Pop: head entry is valid when head_ptr≠fill_ptr. On id_valid_o & id_ready_i, head_ptr++.
- Issue condition: rom_req_o = rst & ~branch_flag_i & (alloc_cnt + discard_cnt < DEPTH). alloc_cnt counts slots between head_ptr and alloc_ptr. Counters are clog2(DEPTH)+1 bits wide.
- Redirect (branch_flag_i=1):
  - pc <= branch_target_i.
  - All pointers are reset to 0.
  - discard_cnt <= discard_cnt + outstanding − (rom_rvalid_i ? 1 : 0), where outstanding = alloc_ptr − fill_ptr.
  - id_valid_o is forced to 0 in the redirect cycle; no pop occurs.
  - The rvalid arriving in the redirect cycle is dropped.
- Discard: while discard_cnt>0, each rom_rvalid_i decrements discard_cnt and its data is dropped.
- Illegal stimulus: rom_rvalid_i with no outstanding and no pending discard. It is ignored, and an assertion is raised in simulation.
- Reset values:
  - pc=RESET_PC, pointers=0, discard_cnt=0.
  - rom_req_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
  - rom_addr_o=RESET_PC.

## Timing
- Accepted request at cycle t; the response may arrive at t+1 or later.
- Without bypass: an entry filled at cycle r appears on id_valid_o at r+1.
- Sustained throughput: 1 instr/cycle when rom_gnt_i=1, id_ready_i=1, and DEPTH ≥ ROM latency + 1.
- Full: no request while alloc_cnt+discard_cnt=DEPTH. A simultaneous pop frees the slot for the next cycle, not the current one.
- Empty: id_valid_o=0, and id_pc_o/id_inst_o hold their last values.
- Simultaneous fill and pop on a non-empty queue: both take effect, and the occupancy count is unchanged.
- Reset mid-operation: all state clears immediately. Responses arriving after reset deasserts are illegal stimulus; the environment must drain the ROM before releasing reset.
- The first request is issued in the first clock after rst rises, at addr=RESET_PC.

## Configuration
- FETCH_BUF_BYPASS_EN defined: when the queue has no filled entries and a non-discarded rom_rvalid_i arrives for the head slot:
  - id_valid_o=1 in that same cycle, with id_inst_o=rom_data_i and id_pc_o=slot pc.
  - If id_ready_i=1, the entry is consumed without being stored, and head_ptr and fill_ptr both advance.
  - Fetch-to-ID latency is reduced by one cycle. This adds a combinational path from rom_rvalid_i/rom_data_i to the id_* outputs.
- Undefined: all id_* outputs are driven from the queue only, with no combinational path from the ROM side.

## Test plan
- Reset and basic fetch: release rst with rom_gnt_i=1, 1-cycle ROM, id_ready_i=1 → requests at 0x0, 0x4, 0x8 on consecutive cycles; id_pc_o sequence 0x0, 0x4, 0x8 with matching instructions, one per cycle.
- Backpressure: DEPTH=4, id_ready_i=0 → exactly 4 requests accepted, then rom_req_o=0. Raise id_ready_i → 4 entries drain in order, and the next request is at 0x10.
- Redirect with responses in flight: 3-cycle ROM latency, 3 outstanding, branch_flag_i with target 0x100 → the 3 late responses are dropped. The next id_pc_o is 0x100, and no stale instruction reaches ID.
- Redirect coincident with rvalid and id_ready_i: that rvalid is dropped, no pop occurs, discard_cnt equals outstanding−1, and id_valid_o=0 in the redirect cycle.
- Grant stalls and PC wrap: RESET_PC=0xFFFFFFF8, rom_gnt_i toggling → address holds during the stall, then the sequence is 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- Bypass: with FETCH_BUF_BYPASS_EN on an empty queue, the response for 0x0 shows on id_inst_o in the same cycle as rom_rvalid_i. Without the macro it shows one cycle later.

Source files
------------

// File: rtl/fetch_buf.sv
// Instruction-fetch unit: owns the PC, issues pipelined ROM requests and queues {pc, inst} pairs for ID.
// Optional same-cycle response bypass to the ID outputs is enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_buf #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [ADDR_W-1:0]  PC_STEP  = ADDR_W'(4)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_gnt_i,
    input  logic              rom_rvalid_i,
    input  logic [DATA_W-1:0] rom_data_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    input  logic              id_ready_i
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PW-1:0]     alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]     head_ptr_q, head_ptr_d;
    logic [PW-1:0]     discard_cnt_q, discard_cnt_d;
    logic [ADDR_W-1:0] hold_pc_q;
    logic [DATA_W-1:0] hold_inst_q;

    logic [ADDR_W-1:0] slot_pc_q   [DEPTH];
    logic [DATA_W-1:0] slot_inst_q [DEPTH];

    logic [PW-1:0]     alloc_cnt;
    logic [PW-1:0]     outstanding;
    logic [PW-1:0]     discard_total;
    logic [PW-1:0]     discard_redir;
    logic [CW-1:0]     occupancy;
    logic              accept;
    logic              rsp_live;
    logic              fill;
    logic              q_nonempty;
    logic              head_show;
    logic              bypass;
    logic              pop;
    logic [IW-1:0]     head_idx;

    assign alloc_cnt   = alloc_ptr_q - head_ptr_q;
    assign outstanding = alloc_ptr_q - fill_ptr_q;
    assign occupancy   = {1'b0, alloc_cnt} + {1'b0, discard_cnt_q};

    assign rom_req_o  = rst & ~branch_flag_i & (occupancy < CW'(DEPTH));
    assign rom_addr_o = pc_q;
    assign accept     = rom_req_o & rom_gnt_i;

    // A response is kept only when nothing is pending discard and a slot is awaiting data.
    assign rsp_live   = rom_rvalid_i & (discard_cnt_q == '0) & (outstanding != '0);
    assign fill       = rsp_live & ~branch_flag_i;
    assign q_nonempty = head_ptr_q != fill_ptr_q;
    assign head_idx   = head_ptr_q[IW-1:0];

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass = ~q_nonempty & rsp_live;
`else
    assign bypass = 1'b0;
`endif

    assign head_show  = q_nonempty | bypass;
    assign id_valid_o = ~branch_flag_i & head_show;
    assign id_pc_o    = head_show ? slot_pc_q[head_idx] : hold_pc_q;
    assign id_inst_o  = q_nonempty ? slot_inst_q[head_idx] :
                        bypass     ? rom_data_i : hold_inst_q;
    assign pop        = id_valid_o & id_ready_i;

    assign discard_total = discard_cnt_q + outstanding;
    assign discard_redir = (rom_rvalid_i && discard_total != '0) ? discard_total - PW'(1) : discard_total;

    always_comb begin
        pc_d          = pc_q;
        alloc_ptr_d   = alloc_ptr_q;
        fill_ptr_d    = fill_ptr_q;
        head_ptr_d    = head_ptr_q;
        discard_cnt_d = discard_cnt_q;
        if (branch_flag_i) begin
            pc_d          = branch_target_i;
            alloc_ptr_d   = '0;
            fill_ptr_d    = '0;
            head_ptr_d    = '0;
            discard_cnt_d = discard_redir;
        end else begin
            if (accept) begin
                pc_d        = pc_q + PC_STEP;
                alloc_ptr_d = alloc_ptr_q + PW'(1);
            end
            if (fill) fill_ptr_d = fill_ptr_q + PW'(1);
            if (pop) head_ptr_d = head_ptr_q + PW'(1);
            if (rom_rvalid_i && discard_cnt_q != '0) discard_cnt_d = discard_cnt_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            alloc_ptr_q   <= '0;
            fill_ptr_q    <= '0;
            head_ptr_q    <= '0;
            discard_cnt_q <= '0;
            hold_pc_q     <= '0;
            hold_inst_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            alloc_ptr_q   <= alloc_ptr_d;
            fill_ptr_q    <= fill_ptr_d;
            head_ptr_q    <= head_ptr_d;
            discard_cnt_q <= discard_cnt_d;
            hold_pc_q     <= id_pc_o;
            hold_inst_q   <= id_inst_o;
        end
    end

    // Slot PCs are captured at issue, instructions at fill; storage needs no reset.
    always_ff @(posedge clk) begin
        if (accept) slot_pc_q[alloc_ptr_q[IW-1:0]] <= pc_q;
        if (fill) slot_inst_q[fill_ptr_q[IW-1:0]] <= rom_data_i;
    end

    assert property (@(posedge clk) disable iff (!rst)
        rom_rvalid_i |-> (discard_cnt_q != '0 || outstanding != '0));

endmodule

// File: tb/tb_fetch_buf.sv
// Self-checking bench for fetch_buf: behavioural ROM with fixed latency, {pc, inst} scoreboard,
// a per-cycle vector table for backpressure, and hand sequences for redirect, wrap and bypass.
`timescale 1ns/1ps
module tb_fetch_buf;

`ifdef FETCH_BUF_BYPASS_EN
    localparam int ID_LAT = 0;
`else
    localparam int ID_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_req, rom_gnt, rom_rvalid, branch, id_valid, id_ready;
    logic [31:0] rom_addr, rom_data, target, id_pc, id_inst;
    logic        w_req, w_gnt, w_valid;
    logic [31:0] w_addr, w_pc, w_inst;

    always #5 clk = ~clk;

    fetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'd4)) u_dut (
        .clk(clk), .rst(rst),
        .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_gnt_i(rom_gnt),
        .rom_rvalid_i(rom_rvalid), .rom_data_i(rom_data),
        .branch_flag_i(branch), .branch_target_i(target),
        .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst), .id_ready_i(id_ready)
    );

    fetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) u_wrap (
        .clk(clk), .rst(rst),
        .rom_req_o(w_req), .rom_addr_o(w_addr), .rom_gnt_i(w_gnt),
        .rom_rvalid_i(1'b0), .rom_data_i(32'h0),
        .branch_flag_i(1'b0), .branch_target_i(32'h0),
        .id_valid_o(w_valid), .id_pc_o(w_pc), .id_inst_o(w_inst), .id_ready_i(1'b1)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { int due; logic [31:0] addr; } rsp_t;
    typedef struct { logic gnt; logic ready; logic exp_req; logic [31:0] exp_addr; } vec_t;

    exp_t        exp_q[$];
    rsp_t        rom_q[$];
    int          acc_cyc[$];
    logic [31:0] acc_addr[$];
    int          pop_cyc[$];
    logic [31:0] pop_pc[$];
    int          rv_cyc[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] model_pc = 32'h0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] popc(input int i);
        if (i < pop_pc.size()) return pop_pc[i];
        return 32'hDEAD_BEEF;
    endfunction
    function automatic int popcyc(input int i);
        if (i < pop_cyc.size()) return pop_cyc[i];
        return -1;
    endfunction
    function automatic logic [31:0] accaddr(input int i);
        if (i < acc_addr.size()) return acc_addr[i];
        return 32'hDEAD_BEEF;
    endfunction
    function automatic int acccyc(input int i);
        if (i < acc_cyc.size()) return acc_cyc[i];
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step_v(input bit en, input logic er, input logic [31:0] ea);
        exp_t e;
        rom_rvalid = 1'b0;
        rom_data   = '0;
        if (rom_q.size() != 0 && rom_q[0].due == cyc) begin
            rom_rvalid = 1'b1;
            rom_data   = inst_of(rom_q[0].addr);
            void'(rom_q.pop_front());
        end
        @(negedge clk);
        if (en) begin
            chk("vec_req", rom_req, er);
            chk("vec_addr", rom_addr, ea);
        end
        if (rom_rvalid) rv_cyc.push_back(cyc);
        if (branch) begin
            chk("redirect_valid", id_valid, 1'b0);
            chk("redirect_req", rom_req, 1'b0);
            exp_q.delete();
            model_pc = target;
        end else begin
            if (id_valid && id_ready) begin
                pop_cyc.push_back(cyc);
                pop_pc.push_back(id_pc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_pop: got pc %h expected no entry", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", id_pc, e.pc);
                    chk("id_inst", id_inst, e.inst);
                end
            end
            if (rom_req && rom_gnt) begin
                chk("rom_addr", rom_addr, model_pc);
                rom_q.push_back('{due: cyc + lat, addr: rom_addr});
                exp_q.push_back('{pc: model_pc, inst: inst_of(model_pc)});
                acc_cyc.push_back(cyc);
                acc_addr.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        step_v(1'b0, 1'b0, 32'h0);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || rom_q.size() != 0); i++) step();
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rom_gnt = 1'b0;
        branch  = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 20 && rom_q.size() != 0; i++) step();
        rom_rvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", rom_req, 1'b0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        @(posedge clk);
        #1;
        exp_q.delete(); rom_q.delete();
        acc_cyc.delete(); acc_addr.delete();
        pop_cyc.delete(); pop_pc.delete(); rv_cyc.delete();
        model_pc = 32'h0;
        cyc = 0;
        rst = 1'b1;
    endtask

    vec_t        tbl[8];
    logic        wrap_gnt[6];
    logic [31:0] wrap_addr[6];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h00};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h04};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h08};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h0C};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h10};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h10};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h10};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h10};
        wrap_gnt  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0};

        rom_gnt = 1'b0; rom_rvalid = 1'b0; rom_data = '0;
        branch = 1'b0; target = '0; id_ready = 1'b1; w_gnt = 1'b0;

        // Power-on reset, then PC wrap with grant stalls on the second instance.
        @(negedge clk);
        chk("rst_req", rom_req, 1'b0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_valid", id_valid, 1'b0);
        chk("wrap_rst_req", w_req, 1'b0);
        chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w_gnt = wrap_gnt[i];
            @(negedge clk);
            chk("wrap_req", w_req, 1'b1);
            chk("wrap_addr", w_addr, wrap_addr[i]);
            chk("wrap_valid", w_valid, 1'b0);
            chk("wrap_hold_pc", w_pc, 32'h0);
            chk("wrap_hold_inst", w_inst, 32'h0);
            @(posedge clk);
            #1;
        end
        w_gnt = 1'b0;

        // Basic fetch with a 1-cycle ROM.
        do_reset();
        lat = 1; rom_gnt = 1'b1; id_ready = 1'b1;
        repeat (3) step();
        rom_gnt = 1'b0;
        drain("basic", 20);
        for (int i = 0; i < 3; i++) begin
            chk("basic_acc_addr", accaddr(i), 32'(4 * i));
            chk("basic_acc_cyc", acccyc(i), i);
            chk("basic_pop_pc", popc(i), 32'(4 * i));
            chk("basic_pop_cyc", popcyc(i), 1 + ID_LAT + i);
        end
        rom_rvalid = 1'b0;
        @(negedge clk);
        chk("empty_valid", id_valid, 1'b0);
        chk("empty_hold_pc", id_pc, 32'h8);
        chk("empty_hold_inst", id_inst, inst_of(32'h8));
        @(posedge clk);
        #1;
        cyc++;

        // Backpressure: four slots fill, then the pop frees one slot a cycle later.
        do_reset();
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            rom_gnt  = tbl[i].gnt;
            id_ready = tbl[i].ready;
            step_v(1'b1, tbl[i].exp_req, tbl[i].exp_addr);
        end
        chk("bp_accepts_before_drain", acc_addr.size(), 5);
        chk("bp_fifth_addr", accaddr(4), 32'h10);
        chk("bp_fifth_cyc", acccyc(4), 7);
        rom_gnt = 1'b0;
        drain("bp", 30);
        for (int i = 0; i < 5; i++) chk("bp_pop_pc", popc(i), 32'(4 * i));

        // Redirect with three responses in flight, none coincident.
        do_reset();
        lat = 4; rom_gnt = 1'b1; id_ready = 1'b1;
        repeat (3) step();
        branch = 1'b1; target = 32'h100;
        step();
        branch = 1'b0;
        repeat (3) step();
        rom_gnt = 1'b0;
        drain("redir", 40);
        chk("redir_first_acc", accaddr(3), 32'h100);
        chk("redir_first_acc_cyc", acccyc(3), 4);
        chk("redir_first_pop", popc(0), 32'h100);
        chk("redir_pop_count", pop_pc.size(), acc_addr.size() - 3);

        // Redirect coincident with a response and id_ready.
        do_reset();
        lat = 3; rom_gnt = 1'b1; id_ready = 1'b1;
        repeat (3) step();
        branch = 1'b1; target = 32'h200;
        step();
        branch = 1'b0;
        chk("coinc_rvalid_seen", rv_cyc.size(), 1);
        chk("coinc_discard_cnt", 32'(u_dut.discard_cnt_q), 32'd2);
        chk("coinc_no_pop", pop_pc.size(), 0);
        repeat (2) step();
        rom_gnt = 1'b0;
        drain("coinc", 40);
        chk("coinc_first_pop", popc(0), 32'h200);

        // Fetch-to-ID latency on an empty queue.
        do_reset();
        lat = 2; rom_gnt = 1'b1; id_ready = 1'b1;
        step();
        rom_gnt = 1'b0;
        drain("lat", 20);
        chk("lat_rvalid_cyc", (rv_cyc.size() != 0) ? rv_cyc[0] : -1, 2);
        chk("lat_pop_cyc", popcyc(0), 2 + ID_LAT);
        chk("lat_pop_pc", popc(0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
